// File: rtl/core_dec_iq.sv
// core_dec_iq: instruction queue + RV32I decode front-end with load-use interlock.
module core_dec_iq #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned LU_STALL = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          if_vld,
  output logic                          if_rdy,
  input  logic [31:0]                   if_inst,
  input  logic [31:0]                   if_pc,
  input  logic                          dec_flush,
  input  logic                          ex_rdy,
  output logic                          ex_vld,
  output logic [31:0]                   ex_pc,
  output logic [3:0]                    ex_cls,
  output logic [3:0]                    ex_funct,
  output logic [4:0]                    ex_rs1,
  output logic [4:0]                    ex_rs2,
  output logic [4:0]                    ex_rd,
  output logic                          ex_we,
  output logic [31:0]                   ex_imm,
  output logic [$clog2(IQ_DEPTH+1)-1:0] iq_cnt
);

  localparam int unsigned PW = $clog2(IQ_DEPTH);
  localparam int unsigned CW = $clog2(IQ_DEPTH + 1);
  localparam logic        LU_EN = (LU_STALL != 0);

  localparam logic [3:0] CLS_ILL   = 4'd0;
  localparam logic [3:0] CLS_R     = 4'd1;
  localparam logic [3:0] CLS_I     = 4'd2;
  localparam logic [3:0] CLS_LUI   = 4'd3;
  localparam logic [3:0] CLS_AUIPC = 4'd4;
  localparam logic [3:0] CLS_BR    = 4'd5;
  localparam logic [3:0] CLS_JAL   = 4'd6;
  localparam logic [3:0] CLS_JALR  = 4'd7;
  localparam logic [3:0] CLS_LD    = 4'd8;
  localparam logic [3:0] CLS_ST    = 4'd9;

  logic [31:0]   mem_inst [IQ_DEPTH];
  logic [31:0]   mem_pc   [IQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    lu_cnt;
  logic [4:0]    ld_rd;

  logic [31:0] h_inst;
  logic [31:0] h_pc;
  logic        h_vld;
  logic [3:0]  d_cls;
  logic [3:0]  d_funct;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [4:0]  d_rd;
  logic [31:0] d_imm;
  logic        use1;
  logic        use2;

  logic push;
  logic pop;
  logic ld_acc;
  logic pending;
  logic [4:0] prd;
  logic block;

  assign if_rdy = (iq_cnt != CW'(IQ_DEPTH));
  assign push   = if_vld & if_rdy & ~dec_flush;
  assign h_vld  = (iq_cnt != '0);
  assign h_inst = mem_inst[rd_ptr];
  assign h_pc   = mem_pc[rd_ptr];

  // Decode the queue head into the execute bundle fields.
  always_comb begin
    d_cls   = CLS_ILL;
    d_rs1   = 5'd0;
    d_rs2   = 5'd0;
    d_rd    = 5'd0;
    d_imm   = 32'd0;
    use1    = 1'b0;
    use2    = 1'b0;
    d_funct = {h_inst[30], h_inst[14:12]};
    case (h_inst[6:0])
      7'b0110011: begin
        d_cls = CLS_R; use1 = 1'b1; use2 = 1'b1; d_rd = h_inst[11:7];
      end
      7'b0010011: begin
        d_cls = CLS_I; use1 = 1'b1; d_rd = h_inst[11:7];
        d_imm = {{20{h_inst[31]}}, h_inst[31:20]};
      end
      7'b0110111: begin
        d_cls = CLS_LUI; d_rd = h_inst[11:7];
        d_imm = {h_inst[31:12], 12'b0};
      end
      7'b0010111: begin
        d_cls = CLS_AUIPC; d_rd = h_inst[11:7];
        d_imm = {h_inst[31:12], 12'b0};
      end
      7'b1100011: begin
        d_cls = CLS_BR; use1 = 1'b1; use2 = 1'b1;
        d_imm = {{19{h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25], h_inst[11:8], 1'b0};
      end
      7'b1101111: begin
        d_cls = CLS_JAL; d_rd = h_inst[11:7];
        d_imm = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20], h_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        d_cls = CLS_JALR; use1 = 1'b1; d_rd = h_inst[11:7];
        d_imm = {{20{h_inst[31]}}, h_inst[31:20]};
      end
      7'b0000011: begin
        d_cls = CLS_LD; use1 = 1'b1; d_rd = h_inst[11:7];
        d_imm = {{20{h_inst[31]}}, h_inst[31:20]};
      end
      7'b0100011: begin
        d_cls = CLS_ST; use1 = 1'b1; use2 = 1'b1;
        d_imm = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
      end
      default: ;
    endcase
    if (use1) d_rs1 = h_inst[19:15];
    if (use2) d_rs2 = h_inst[24:20];
  end

  // Load-use interlock: hold a dependent instruction or a second load while a load is in its shadow.
  always_comb begin
    ld_acc  = ex_vld & ex_rdy & (ex_cls == CLS_LD) & ex_we & LU_EN;
    pending = (lu_cnt != 3'd0) | ld_acc;
    prd     = (lu_cnt != 3'd0) ? ld_rd : ex_rd;
    block   = pending & ((d_cls == CLS_LD) |
                         (use1 & (d_rs1 == prd)) |
                         (use2 & (d_rs2 == prd)));
    pop     = h_vld & ~block & (~ex_vld | ex_rdy) & ~dec_flush;
  end

  // Queue storage; payload needs no reset since occupancy gates its use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= if_inst;
      mem_pc[wr_ptr]   <= if_pc;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      iq_cnt <= '0;
    end else if (dec_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      iq_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      iq_cnt <= iq_cnt + CW'(push) - CW'(pop);
    end
  end

  // Interlock counter and the destination of the load in its shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt <= 3'd0;
      ld_rd  <= 5'd0;
    end else if (dec_flush) begin
      lu_cnt <= 3'd0;
    end else if (ld_acc) begin
      lu_cnt <= 3'(LU_STALL - 1);
      ld_rd  <= ex_rd;
    end else if (lu_cnt != 3'd0) begin
      lu_cnt <= lu_cnt - 3'd1;
    end
  end

  // Execute bundle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld   <= 1'b0;
      ex_pc    <= 32'd0;
      ex_cls   <= 4'd0;
      ex_funct <= 4'd0;
      ex_rs1   <= 5'd0;
      ex_rs2   <= 5'd0;
      ex_rd    <= 5'd0;
      ex_we    <= 1'b0;
      ex_imm   <= 32'd0;
    end else if (dec_flush) begin
      ex_vld <= 1'b0;
    end else if (pop) begin
      ex_vld   <= 1'b1;
      ex_pc    <= h_pc;
      ex_cls   <= d_cls;
      ex_funct <= d_funct;
      ex_rs1   <= d_rs1;
      ex_rs2   <= d_rs2;
      ex_rd    <= d_rd;
      ex_we    <= (d_rd != 5'd0);
      ex_imm   <= d_imm;
    end else if (ex_rdy) begin
      ex_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_dec_iq.sv
// Directed bench for core_dec_iq (IQ_DEPTH=4, LU_STALL=2).
module tb_core_dec_iq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_vld;
  logic        if_rdy;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        dec_flush;
  logic        ex_rdy;
  logic        ex_vld;
  logic [31:0] ex_pc;
  logic [3:0]  ex_cls;
  logic [3:0]  ex_funct;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic [31:0] ex_imm;
  logic [2:0]  iq_cnt;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0000_A283;
  localparam logic [31:0] ADDD = 32'h0052_8333;
  localparam logic [31:0] ADDI_IND = 32'h0031_0333;

  core_dec_iq #(.IQ_DEPTH(4), .LU_STALL(2)) dut (
    .clk(clk), .rst_n(rst_n), .if_vld(if_vld), .if_rdy(if_rdy),
    .if_inst(if_inst), .if_pc(if_pc), .dec_flush(dec_flush),
    .ex_rdy(ex_rdy), .ex_vld(ex_vld), .ex_pc(ex_pc), .ex_cls(ex_cls),
    .ex_funct(ex_funct), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_we(ex_we), .ex_imm(ex_imm), .iq_cnt(iq_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_vld = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
    dec_flush = 1'b0; ex_rdy = 1'b0;
    tick(); tick();
    checks++; if (ex_vld !== 1'b0) begin failures++; $display("FAIL reset_ex_vld got=%0b exp=0", ex_vld); end
    checks++; if (iq_cnt !== 3'd0) begin failures++; $display("FAIL reset_iq_cnt got=%0d exp=0", iq_cnt); end
    checks++; if (if_rdy !== 1'b1) begin failures++; $display("FAIL reset_if_rdy got=%0b exp=1", if_rdy); end
    checks++; if ({ex_pc, ex_imm} !== 64'd0) begin failures++; $display("FAIL reset_data pc=%h imm=%h exp=0", ex_pc, ex_imm); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    ex_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_vld = 1'b1; if_inst = ADDI; if_pc = 32'h100 + 32'(4 * k);
      tick();
      if (k == 0) begin
        checks++; if (ex_vld !== 1'b0) begin failures++; $display("FAIL stream_lat got=%0b exp=0", ex_vld); end
      end else begin
        checks++;
        if (ex_vld !== 1'b1 || ex_pc !== 32'h100 + 32'(4 * (k - 1))) begin
          failures++; $display("FAIL stream_pc k=%0d vld=%0b pc=%h exp=%h", k, ex_vld, ex_pc, 32'h100 + 32'(4 * (k - 1)));
        end
      end
    end
    if_vld = 1'b0;
    tick();
    checks++; if (ex_vld !== 1'b1 || ex_pc !== 32'h10C) begin failures++; $display("FAIL stream_last vld=%0b pc=%h exp=10c", ex_vld, ex_pc); end
    checks++;
    if (ex_cls !== 4'd2 || ex_imm !== 32'd5 || ex_rd !== 5'd1 || ex_we !== 1'b1 || ex_funct !== 4'd0 || ex_rs1 !== 5'd0) begin
      failures++; $display("FAIL stream_fields cls=%0d imm=%h rd=%0d we=%0b funct=%0d rs1=%0d exp=2/5/1/1/0/0",
                           ex_cls, ex_imm, ex_rd, ex_we, ex_funct, ex_rs1);
    end
    tick();
    checks++; if (ex_vld !== 1'b0 || iq_cnt !== 3'd0) begin failures++; $display("FAIL stream_drain vld=%0b cnt=%0d exp=0/0", ex_vld, iq_cnt); end
  endtask

  task automatic test_full();
    ex_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if_vld = 1'b1; if_inst = ADDI; if_pc = 32'h200 + 32'(4 * k);
      tick();
    end
    checks++; if (iq_cnt !== 3'd4 || if_rdy !== 1'b0) begin failures++; $display("FAIL full_state cnt=%0d rdy=%0b exp=4/0", iq_cnt, if_rdy); end
    checks++; if (ex_vld !== 1'b1 || ex_pc !== 32'h200) begin failures++; $display("FAIL full_held vld=%0b pc=%h exp=1/200", ex_vld, ex_pc); end
    if_pc = 32'h214;
    tick();
    if_vld = 1'b0;
    checks++; if (iq_cnt !== 3'd4) begin failures++; $display("FAIL full_no_push cnt=%0d exp=4", iq_cnt); end
    ex_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ex_vld !== 1'b1 || ex_pc !== 32'h200 + 32'(4 * k) || iq_cnt !== 3'(4 - k) || if_rdy !== (k != 0)) begin
        failures++; $display("FAIL full_drain k=%0d vld=%0b pc=%h cnt=%0d rdy=%0b exp_pc=%h exp_cnt=%0d",
                             k, ex_vld, ex_pc, iq_cnt, if_rdy, 32'h200 + 32'(4 * k), 4 - k);
      end
      tick();
    end
    checks++; if (ex_vld !== 1'b0) begin failures++; $display("FAIL full_empty vld=%0b exp=0", ex_vld); end
  endtask

  task automatic lu_pair(input logic [31:0] second, input int exp_bub, input string name);
    int bub;
    bit found;
    ex_rdy = 1'b1;
    if_vld = 1'b1; if_inst = LW; if_pc = 32'h300;
    tick();
    if_inst = second; if_pc = 32'h304;
    tick();
    if_vld = 1'b0;
    checks++; if (ex_vld !== 1'b1 || ex_pc !== 32'h300 || ex_cls !== 4'd8) begin failures++; $display("FAIL %s_ld vld=%0b pc=%h cls=%0d", name, ex_vld, ex_pc, ex_cls); end
    bub = 0; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (ex_vld === 1'b1 && ex_pc === 32'h304) found = 1'b1;
      else bub++;
    end
    checks++; if (!found || bub != exp_bub) begin failures++; $display("FAIL %s_bubbles found=%0b got=%0d exp=%0d", name, found, bub, exp_bub); end
    repeat (4) tick();
  endtask

  task automatic test_load_use();
    lu_pair(ADDD, 2, "lu_dep");
    lu_pair(ADDI_IND, 0, "lu_indep");
    lu_pair(LW, 2, "lu_ldld");
  endtask

  task automatic decode_one(input logic [31:0] inst, input logic [3:0] cls, input logic [31:0] imm,
                            input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                            input logic [4:0] rs2, input string name);
    ex_rdy = 1'b1;
    if_vld = 1'b1; if_inst = inst; if_pc = 32'h500;
    tick();
    if_vld = 1'b0;
    tick();
    checks++;
    if (ex_vld !== 1'b1 || ex_cls !== cls || ex_imm !== imm || ex_rd !== rd || ex_we !== we || ex_rs1 !== rs1 || ex_rs2 !== rs2) begin
      failures++; $display("FAIL %s vld=%0b cls=%0d imm=%h rd=%0d we=%0b rs1=%0d rs2=%0d exp cls=%0d imm=%h rd=%0d we=%0b rs1=%0d rs2=%0d",
                           name, ex_vld, ex_cls, ex_imm, ex_rd, ex_we, ex_rs1, ex_rs2, cls, imm, rd, we, rs1, rs2);
    end
    tick();
  endtask

  task automatic test_imm();
    decode_one(32'hFE00_0EE3, 4'd5, 32'hFFFF_FFFC, 5'd0, 1'b0, 5'd0, 5'd0, "imm_beq");
    decode_one(32'h0010_00EF, 4'd6, 32'h0000_0800, 5'd1, 1'b1, 5'd0, 5'd0, "imm_jal");
    decode_one(32'h1234_5137, 4'd3, 32'h1234_5000, 5'd2, 1'b1, 5'd0, 5'd0, "imm_lui");
    decode_one(32'h0050_A423, 4'd9, 32'h0000_0008, 5'd0, 1'b0, 5'd1, 5'd5, "imm_sw");
    decode_one(32'hFFFF_FFFF, 4'd0, 32'h0000_0000, 5'd0, 1'b0, 5'd0, 5'd0, "imm_ill");
  endtask

  task automatic test_flush();
    ex_rdy = 1'b0;
    if_vld = 1'b1; if_inst = LW; if_pc = 32'h400;
    tick();
    for (int k = 1; k < 4; k++) begin
      if_inst = ADDI; if_pc = 32'h400 + 32'(4 * k);
      tick();
    end
    ex_rdy = 1'b1; if_pc = 32'h410;
    tick();
    ex_rdy = 1'b0; if_vld = 1'b0;
    checks++;
    if (iq_cnt !== 3'd3 || ex_vld !== 1'b1 || ex_pc !== 32'h404 || dut.lu_cnt === 3'd0) begin
      failures++; $display("FAIL flush_pre cnt=%0d vld=%0b pc=%h lu=%0d exp=3/1/404/nonzero", iq_cnt, ex_vld, ex_pc, dut.lu_cnt);
    end
    dec_flush = 1'b1; if_vld = 1'b1; if_inst = ADDI; if_pc = 32'h4F0;
    tick();
    dec_flush = 1'b0; if_vld = 1'b0;
    checks++;
    if (iq_cnt !== 3'd0 || ex_vld !== 1'b0 || dut.lu_cnt !== 3'd0 || if_rdy !== 1'b1) begin
      failures++; $display("FAIL flush_post cnt=%0d vld=%0b lu=%0d rdy=%0b exp=0/0/0/1", iq_cnt, ex_vld, dut.lu_cnt, if_rdy);
    end
    ex_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ex_vld !== 1'b0) begin failures++; $display("FAIL flush_dropped i=%0d vld=%0b pc=%h exp=0", i, ex_vld, ex_pc); end
    end
  endtask

  task automatic test_async_reset();
    ex_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_vld = 1'b1; if_inst = ADDI; if_pc = 32'h600 + 32'(4 * k);
      tick();
    end
    if_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ex_vld !== 1'b0 || iq_cnt !== 3'd0 || if_rdy !== 1'b1) begin failures++; $display("FAIL areset_ctl vld=%0b cnt=%0d rdy=%0b exp=0/0/1", ex_vld, iq_cnt, if_rdy); end
    checks++;
    if (ex_pc !== 32'd0 || ex_imm !== 32'd0 || ex_cls !== 4'd0 || ex_rd !== 5'd0 || ex_we !== 1'b0 || ex_rs1 !== 5'd0 || ex_funct !== 4'd0) begin
      failures++; $display("FAIL areset_data pc=%h imm=%h cls=%0d rd=%0d we=%0b exp=0", ex_pc, ex_imm, ex_cls, ex_rd, ex_we);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_stream();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_load_use();
    test_imm();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
